// File: rtl/sram_bist_pkg.sv
// rtl/sram_bist_pkg.sv - March C- element table, BIST FSM states and shared element indices
//
// Purpose: shared definitions for sram_1p_march_bist and its bench.
//   - ELEM_M0..ELEM_M5: element indices (also reported as the failing element).
//   - bist_state_t: march states reuse the element index as their encoding.
//   - ELEM_* tables: one bit per element, indexed by element number.
//     Bits 6 and 7 (FLUSH, IDLE) are zero so lookups outside a march element are harmless.
package sram_bist_pkg;

  localparam logic [2:0] ELEM_M0 = 3'd0;
  localparam logic [2:0] ELEM_M1 = 3'd1;
  localparam logic [2:0] ELEM_M2 = 3'd2;
  localparam logic [2:0] ELEM_M3 = 3'd3;
  localparam logic [2:0] ELEM_M4 = 3'd4;
  localparam logic [2:0] ELEM_M5 = 3'd5;

  typedef enum logic [2:0] {
    ST_M0    = ELEM_M0,
    ST_M1    = ELEM_M1,
    ST_M2    = ELEM_M2,
    ST_M3    = ELEM_M3,
    ST_M4    = ELEM_M4,
    ST_M5    = ELEM_M5,
    ST_FLUSH = 3'd6,
    ST_IDLE  = 3'd7
  } bist_state_t;

  // Address direction: 1 = descending (M3, M4).
  localparam logic [7:0] ELEM_DOWN    = 8'b0001_1000;
  // Elements with a read followed by a write (M1..M4); the rest have one op.
  localparam logic [7:0] ELEM_TWO_OPS = 8'b0001_1110;
  // First op is a read (M1..M5); M0 starts with a write.
  localparam logic [7:0] ELEM_OP0_RD  = 8'b0011_1110;
  // Background of the first op (0 = all-zeros, 1 = all-ones).
  // The second op, when present, always writes the complement.
  localparam logic [7:0] ELEM_OP0_BG  = 8'b0001_0100;

  function automatic logic [2:0] state_elem(input bist_state_t s);
    return 3'(s);
  endfunction

endpackage

// File: rtl/sram_1p_march_bist_if.sv
// rtl/sram_1p_march_bist_if.sv - functional single-port SRAM bus
//
// Signals:
//   A_ADDR  address          A_DIN  write data     A_BM  write bit mask
//   A_MEN   memory enable    A_WEN  write enable   A_REN read enable
//   A_DOUT  read data (driven by the memory)
// Modports: master (requester side), slave (memory side).
interface sram_1p_march_bist_if #(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_ADDR_WIDTH = 10
);
  logic [P_ADDR_WIDTH-1:0] A_ADDR;
  logic [P_DATA_WIDTH-1:0] A_DIN;
  logic [P_DATA_WIDTH-1:0] A_BM;
  logic                    A_MEN;
  logic                    A_WEN;
  logic                    A_REN;
  logic [P_DATA_WIDTH-1:0] A_DOUT;

  modport master (
    output A_ADDR, A_DIN, A_BM, A_MEN, A_WEN, A_REN,
    input  A_DOUT
  );

  modport slave (
    input  A_ADDR, A_DIN, A_BM, A_MEN, A_WEN, A_REN,
    output A_DOUT
  );
endinterface

// File: rtl/sram_1p_array.sv
// rtl/sram_1p_array.sv - SRAM storage with bit-mask merge, range check and read pipeline
//
// Ports:
//   clk, rst_n        clock, async active-low reset (pipeline and dout only)
//   addr, din, bm     access address, write data, write bit mask
//   men, wen, ren     enables; wen&ren returns the merged new word
//   func              access tag: 1 = functional, 0 = self-test
//   dout              functional read data, holds between functional reads
//   chk_word, chk_vld self-test read data at its arrival edge (not registered here)
module sram_1p_array #(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_ADDR_WIDTH = 10,
  parameter int P_DEPTH      = 1024,
  parameter int P_RD_LAT     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [P_ADDR_WIDTH-1:0] addr,
  input  logic [P_DATA_WIDTH-1:0] din,
  input  logic [P_DATA_WIDTH-1:0] bm,
  input  logic                    men,
  input  logic                    wen,
  input  logic                    ren,
  input  logic                    func,
  output logic [P_DATA_WIDTH-1:0] dout,
  output logic [P_DATA_WIDTH-1:0] chk_word,
  output logic                    chk_vld
);
  localparam int DW = P_DATA_WIDTH;
  localparam int IW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;

  logic [DW-1:0] mem [P_DEPTH];

  logic [IW-1:0] idx;
  logic          in_range;
  logic [DW-1:0] old_word;
  logic [DW-1:0] merged;
  logic [DW-1:0] rd_word;
  logic          rd_vld;

  assign idx      = addr[IW-1:0];
  assign in_range = 32'(addr) < 32'(P_DEPTH);
  assign old_word = mem[idx];
  assign merged   = (old_word & ~bm) | (din & bm);
  // Out-of-range reads return zero; write-through returns the merged word.
  assign rd_word  = !in_range ? '0 : (wen ? merged : old_word);
  assign rd_vld   = men & ren;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (men && wen && in_range) begin
      mem[idx] <= merged;
    end
  end

  // fin_* is the read as it enters the final (output) stage.
  logic [DW-1:0] fin_word;
  logic          fin_vld;
  logic          fin_func;

  if (P_RD_LAT == 2) begin : g_lat2
    logic [DW-1:0] p1_word;
    logic          p1_vld;
    logic          p1_func;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p1_word <= '0;
        p1_vld  <= 1'b0;
        p1_func <= 1'b0;
      end else begin
        p1_vld  <= rd_vld;
        p1_func <= func;
        if (rd_vld) begin
          p1_word <= rd_word;
        end
      end
    end

    assign fin_word = p1_word;
    assign fin_vld  = p1_vld;
    assign fin_func = p1_func;
  end else begin : g_lat1
    assign fin_word = rd_word;
    assign fin_vld  = rd_vld;
    assign fin_func = func;
  end

  // Only functional reads reach dout, so self-test traffic never disturbs it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (fin_vld && fin_func) begin
      dout <= fin_word;
    end
  end

  assign chk_word = fin_word;
  assign chk_vld  = fin_vld & ~fin_func;

endmodule

// File: rtl/sram_1p_march_bist.sv
// rtl/sram_1p_march_bist.sv - single-port SRAM model with built-in March C- self-test
//
// Ports:
//   A_CLK, A_RST_N   clock, async active-low reset
//   bus              functional port (sram_1p_march_bist_if.slave)
//   A_BIST_START     1-cycle start pulse, ignored while busy
//   A_BIST_BUSY      test running, functional port blocked
//   A_BIST_DONE      sticky end-of-test flag, cleared by start
//   A_BIST_FAIL      sticky miscompare flag, cleared by start
// Optional (macro SRAM_1P_BIST_FAIL_LOG_EN):
//   A_BIST_FAIL_ADDR, A_BIST_FAIL_ELEM, A_BIST_FAIL_XOR  first miscompare details
module sram_1p_march_bist
  import sram_bist_pkg::*;
#(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_ADDR_WIDTH = 10,
  parameter int P_DEPTH      = 1024,
  parameter int P_RD_LAT     = 1
) (
  input  logic                    A_CLK,
  input  logic                    A_RST_N,
  sram_1p_march_bist_if.slave     bus,
  input  logic                    A_BIST_START,
  output logic                    A_BIST_BUSY,
  output logic                    A_BIST_DONE,
  output logic                    A_BIST_FAIL
`ifdef SRAM_1P_BIST_FAIL_LOG_EN
  ,
  output logic [P_ADDR_WIDTH-1:0] A_BIST_FAIL_ADDR,
  output logic [2:0]              A_BIST_FAIL_ELEM,
  output logic [P_DATA_WIDTH-1:0] A_BIST_FAIL_XOR
`endif
);
  localparam int DW = P_DATA_WIDTH;
  localparam int AW = P_ADDR_WIDTH;
  localparam logic [AW-1:0] LAST_ADDR  = AW'(P_DEPTH - 1);
  localparam logic [1:0]    FLUSH_LAST = 2'(P_RD_LAT - 1);

  bist_state_t   state;
  logic [AW-1:0] addr_q;
  logic          op_q;      // 0 = first op of the element at this address, 1 = second
  logic [1:0]    flush_q;

  logic [2:0]    elem;
  logic [2:0]    next_elem;
  logic          bist_act;
  logic          bist_rd;
  logic          bist_wr;
  logic          bist_bg;
  logic [DW-1:0] bist_word;
  logic          op_last;
  logic          addr_last;

  assign elem      = state_elem(state);
  assign next_elem = elem + 3'd1;
  assign bist_act  = (state != ST_IDLE) && (state != ST_FLUSH);
  assign bist_rd   = bist_act && !op_q && ELEM_OP0_RD[elem];
  assign bist_wr   = bist_act && !bist_rd;
  assign bist_bg   = ELEM_OP0_BG[elem] ^ op_q;
  assign bist_word = {DW{bist_bg}};
  assign op_last   = !ELEM_TWO_OPS[elem] || op_q;
  assign addr_last = ELEM_DOWN[elem] ? (addr_q == '0) : (addr_q == LAST_ADDR);

  // Port mux: while busy the functional enables are dropped entirely.
  logic [AW-1:0] arr_addr;
  logic [DW-1:0] arr_din;
  logic [DW-1:0] arr_bm;
  logic          arr_men;
  logic          arr_wen;
  logic          arr_ren;
  logic [DW-1:0] chk_word;
  logic          chk_vld;

  assign arr_addr = A_BIST_BUSY ? addr_q    : bus.A_ADDR;
  assign arr_din  = A_BIST_BUSY ? bist_word : bus.A_DIN;
  assign arr_bm   = A_BIST_BUSY ? '1        : bus.A_BM;
  assign arr_men  = A_BIST_BUSY ? bist_act  : bus.A_MEN;
  assign arr_wen  = A_BIST_BUSY ? bist_wr   : bus.A_WEN;
  assign arr_ren  = A_BIST_BUSY ? bist_rd   : bus.A_REN;

  sram_1p_array #(
    .P_DATA_WIDTH (DW),
    .P_ADDR_WIDTH (AW),
    .P_DEPTH      (P_DEPTH),
    .P_RD_LAT     (P_RD_LAT)
  ) u_array (
    .clk      (A_CLK),
    .rst_n    (A_RST_N),
    .addr     (arr_addr),
    .din      (arr_din),
    .bm       (arr_bm),
    .men      (arr_men),
    .wen      (arr_wen),
    .ren      (arr_ren),
    .func     (!A_BIST_BUSY),
    .dout     (bus.A_DOUT),
    .chk_word (chk_word),
    .chk_vld  (chk_vld)
  );

  // Expected value (and fail-log context) travels with the read so it lines
  // up with chk_word at the arrival edge.
  logic [DW-1:0] exp_chk;
`ifdef SRAM_1P_BIST_FAIL_LOG_EN
  logic [AW-1:0] chk_addr;
  logic [2:0]    chk_elem;
`endif

  if (P_RD_LAT == 2) begin : g_exp_lat2
    always_ff @(posedge A_CLK or negedge A_RST_N) begin
      if (!A_RST_N) begin
        exp_chk  <= '0;
`ifdef SRAM_1P_BIST_FAIL_LOG_EN
        chk_addr <= '0;
        chk_elem <= '0;
`endif
      end else begin
        exp_chk  <= bist_word;
`ifdef SRAM_1P_BIST_FAIL_LOG_EN
        chk_addr <= addr_q;
        chk_elem <= elem;
`endif
      end
    end
  end else begin : g_exp_lat1
    assign exp_chk  = bist_word;
`ifdef SRAM_1P_BIST_FAIL_LOG_EN
    assign chk_addr = addr_q;
    assign chk_elem = elem;
`endif
  end

  logic miscmp;
  assign miscmp = chk_vld && (chk_word != exp_chk);

  always_ff @(posedge A_CLK or negedge A_RST_N) begin
    if (!A_RST_N) begin
      state            <= ST_IDLE;
      addr_q           <= '0;
      op_q             <= 1'b0;
      flush_q          <= '0;
      A_BIST_BUSY      <= 1'b0;
      A_BIST_DONE      <= 1'b0;
      A_BIST_FAIL      <= 1'b0;
`ifdef SRAM_1P_BIST_FAIL_LOG_EN
      A_BIST_FAIL_ADDR <= '0;
      A_BIST_FAIL_ELEM <= '0;
      A_BIST_FAIL_XOR  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (A_BIST_START) begin
            state            <= ST_M0;
            addr_q           <= '0;
            op_q             <= 1'b0;
            A_BIST_BUSY      <= 1'b1;
            A_BIST_DONE      <= 1'b0;
            A_BIST_FAIL      <= 1'b0;
`ifdef SRAM_1P_BIST_FAIL_LOG_EN
            A_BIST_FAIL_ADDR <= '0;
            A_BIST_FAIL_ELEM <= '0;
            A_BIST_FAIL_XOR  <= '0;
`endif
          end
        end
        ST_FLUSH: begin
          flush_q <= flush_q + 2'd1;
          if (flush_q == FLUSH_LAST) begin
            state       <= ST_IDLE;
            A_BIST_BUSY <= 1'b0;
            A_BIST_DONE <= 1'b1;
          end
        end
        default: begin
          if (!op_last) begin
            op_q <= 1'b1;
          end else begin
            op_q <= 1'b0;
            if (!addr_last) begin
              addr_q <= ELEM_DOWN[elem] ? addr_q - 1'b1 : addr_q + 1'b1;
            end else if (elem == ELEM_M5) begin
              state   <= ST_FLUSH;
              flush_q <= '0;
            end else begin
              state  <= bist_state_t'(next_elem);
              addr_q <= ELEM_DOWN[next_elem] ? LAST_ADDR : '0;
            end
          end
        end
      endcase

      if (miscmp) begin
        A_BIST_FAIL <= 1'b1;
`ifdef SRAM_1P_BIST_FAIL_LOG_EN
        if (!A_BIST_FAIL) begin
          A_BIST_FAIL_ADDR <= chk_addr;
          A_BIST_FAIL_ELEM <= chk_elem;
          A_BIST_FAIL_XOR  <= chk_word ^ exp_chk;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_sram_1p_march_bist.sv
// tb/tb_sram_1p_march_bist.sv - self-checking bench for sram_1p_march_bist
module tb_sram_1p_march_bist;
  import sram_bist_pkg::*;

  localparam int DW          = 32;
  localparam int AW          = 10;
  localparam int DEPTH       = 16;
  localparam int RD_LAT      = 1;
  localparam int BIST_CYCLES = 10 * DEPTH + RD_LAT;

  logic clk        = 1'b0;
  logic rst_n      = 1'b0;
  logic bist_start = 1'b0;
  logic busy;
  logic done;
  logic fail;
`ifdef SRAM_1P_BIST_FAIL_LOG_EN
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [DW-1:0] fail_xor;
`endif

  sram_1p_march_bist_if #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW)) bus ();

  sram_1p_march_bist #(
    .P_DATA_WIDTH (DW),
    .P_ADDR_WIDTH (AW),
    .P_DEPTH      (DEPTH),
    .P_RD_LAT     (RD_LAT)
  ) dut (
    .A_CLK            (clk),
    .A_RST_N          (rst_n),
    .bus              (bus),
    .A_BIST_START     (bist_start),
    .A_BIST_BUSY      (busy),
    .A_BIST_DONE      (done),
    .A_BIST_FAIL      (fail)
`ifdef SRAM_1P_BIST_FAIL_LOG_EN
    ,
    .A_BIST_FAIL_ADDR (fail_addr),
    .A_BIST_FAIL_ELEM (fail_elem),
    .A_BIST_FAIL_XOR  (fail_xor)
`endif
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] ref_dout;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One functional transaction, updating the reference model, then compare A_DOUT.
  task automatic mem_op(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m,
                        input bit en, input bit we, input bit re, input string tag);
    logic [DW-1:0] old_w;
    logic [DW-1:0] new_w;
    @(negedge clk);
    bus.A_ADDR = a;
    bus.A_DIN  = d;
    bus.A_BM   = m;
    bus.A_MEN  = en;
    bus.A_WEN  = we;
    bus.A_REN  = re;
    if (en) begin
      if (int'(a) < DEPTH) begin
        old_w = ref_mem[int'(a)];
        new_w = old_w;
        for (int b = 0; b < DW; b++) begin
          if (we && m[b]) new_w[b] = d[b];
        end
        if (we) ref_mem[int'(a)] = new_w;
        if (re) ref_dout = new_w;
      end else if (re) begin
        ref_dout = '0;
      end
    end
    @(negedge clk);
    bus.A_MEN = 1'b0;
    bus.A_WEN = 1'b0;
    bus.A_REN = 1'b0;
    check_eq(tag, 64'(bus.A_DOUT), 64'(ref_dout));
  endtask

  // Start a self-test and count BUSY cycles. Optional: emulate a stuck-at-1
  // on bit 0 of word 7, disturb the functional port / re-pulse START while
  // busy, or pull reset at a given busy cycle.
  task automatic run_bist(input bit stuck, input bit disturb, input int abort_at,
                          output int cycles, output int dout_changes, output bit done_early);
    logic [DW-1:0] dout0;
    dout0        = bus.A_DOUT;
    cycles       = 0;
    dout_changes = 0;
    done_early   = 1'b0;
    @(negedge clk);
    bist_start = 1'b1;
    @(negedge clk);
    bist_start = 1'b0;
    while (busy && cycles < 4 * BIST_CYCLES) begin
      cycles++;
      if (done) done_early = 1'b1;
      if (bus.A_DOUT !== dout0) dout_changes++;
      if (stuck) dut.u_array.mem[7] = dut.u_array.mem[7] | 32'h1;
      if (disturb) begin
        case (cycles)
          5: begin
            bus.A_ADDR = AW'(2);
            bus.A_DIN  = 32'h1234_5678;
            bus.A_BM   = '1;
            bus.A_MEN  = 1'b1;
            bus.A_WEN  = 1'b1;
            bus.A_REN  = 1'b1;
          end
          6: begin
            bus.A_MEN = 1'b0;
            bus.A_WEN = 1'b0;
            bus.A_REN = 1'b0;
          end
          50: bist_start = 1'b1;
          51: bist_start = 1'b0;
          default: ;
        endcase
      end
      if (abort_at != 0 && cycles == abort_at) begin
        check_eq("abort_fail_before", 64'(fail), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_busy", 64'(busy), 64'(0));
        check_eq("abort_done", 64'(done), 64'(0));
        check_eq("abort_fail", 64'(fail), 64'(0));
      end
      @(negedge clk);
    end
  endtask

  int            cyc;
  int            dchg;
  bit            dearly;
  logic [AW-1:0] ra;

  initial begin
    bus.A_ADDR = '0;
    bus.A_DIN  = '0;
    bus.A_BM   = '0;
    bus.A_MEN  = 1'b0;
    bus.A_WEN  = 1'b0;
    bus.A_REN  = 1'b0;
    ref_dout   = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    repeat (3) @(negedge clk);
    check_eq("rst_dout", 64'(bus.A_DOUT), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_done", 64'(done), 64'(0));
    check_eq("rst_fail", 64'(fail), 64'(0));
`ifdef SRAM_1P_BIST_FAIL_LOG_EN
    check_eq("rst_fail_addr", 64'(fail_addr), 64'(0));
    check_eq("rst_fail_elem", 64'(fail_elem), 64'(0));
    check_eq("rst_fail_xor", 64'(fail_xor), 64'(0));
`endif
    rst_n = 1'b1;

    // Directed functional cases.
    mem_op(AW'(5), 32'hDEAD_BEEF, '1, 1'b1, 1'b1, 1'b0, "wr5");
    mem_op(AW'(5), '0, '0, 1'b1, 1'b0, 1'b1, "rd5");
    check_eq("rd5_value", 64'(bus.A_DOUT), 64'(32'hDEAD_BEEF));
    mem_op(AW'(3), 32'hFFFF_FFFF, '1, 1'b1, 1'b1, 1'b0, "wr3");
    mem_op(AW'(3), 32'h0, 32'h0000_FFFF, 1'b1, 1'b1, 1'b1, "wt3");
    check_eq("wt3_value", 64'(bus.A_DOUT), 64'(32'hFFFF_0000));
    mem_op(AW'(4), 32'hA5A5_A5A5, '1, 1'b1, 1'b1, 1'b0, "wr4");
    mem_op(AW'(20), 32'h1111_1111, '1, 1'b1, 1'b1, 1'b0, "wr_oor");
    mem_op(AW'(20), '0, '0, 1'b1, 1'b0, 1'b1, "rd_oor");
    check_eq("rd_oor_zero", 64'(bus.A_DOUT), 64'(0));
    mem_op(AW'(4), '0, '0, 1'b1, 1'b0, 1'b1, "rd4_after_oor");
    check_eq("rd4_value", 64'(bus.A_DOUT), 64'(32'hA5A5_A5A5));

    // Randomized functional traffic against the model.
    for (int i = 0; i < DEPTH; i++) mem_op(AW'(i), $urandom, '1, 1'b1, 1'b1, 1'b0, "rand_init");
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) ra = AW'($urandom_range(DEPTH, 2 * DEPTH - 1));
      else                          ra = AW'($urandom_range(0, DEPTH - 1));
      mem_op(ra, $urandom, $urandom, $urandom_range(0, 5) != 0,
             $urandom_range(0, 1) != 0, $urandom_range(0, 2) != 0, "rand_op");
    end
    mem_op(AW'(5), '0, '0, 1'b1, 1'b0, 1'b1, "pre_bist_rd");

    // Clean self-test with blocked functional write and ignored START.
    run_bist(1'b0, 1'b1, 0, cyc, dchg, dearly);
    check_eq("clean_cycles", 64'(cyc), 64'(BIST_CYCLES));
    check_eq("clean_done", 64'(done), 64'(1));
    check_eq("clean_fail", 64'(fail), 64'(0));
    check_eq("clean_busy_after", 64'(busy), 64'(0));
    check_eq("clean_dout_hold", 64'(dchg), 64'(0));
    check_eq("clean_done_early", 64'(dearly), 64'(0));
    // March C- ends with w0 everywhere, so the array is all zeros now.
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    mem_op(AW'(2), '0, '0, 1'b1, 1'b0, 1'b1, "blocked_wr2");
    check_eq("blocked_wr2_zero", 64'(bus.A_DOUT), 64'(0));

    // Stuck-at-1 on bit 0 of word 7.
    mem_op(AW'(9), '0, '0, 1'b1, 1'b0, 1'b1, "pre_stuck_rd");
    run_bist(1'b1, 1'b0, 0, cyc, dchg, dearly);
    check_eq("stuck_cycles", 64'(cyc), 64'(BIST_CYCLES));
    check_eq("stuck_fail", 64'(fail), 64'(1));
    check_eq("stuck_done", 64'(done), 64'(1));
    check_eq("stuck_dout_hold", 64'(dchg), 64'(0));
`ifdef SRAM_1P_BIST_FAIL_LOG_EN
    check_eq("stuck_fail_addr", 64'(fail_addr), 64'(7));
    check_eq("stuck_fail_elem", 64'(fail_elem), 64'(ELEM_M1));
    check_eq("stuck_fail_xor", 64'(fail_xor), 64'(1));
`endif

    // Reset 40 cycles into a test (with a fail already flagged).
    run_bist(1'b1, 1'b0, 40, cyc, dchg, dearly);
    check_eq("abort_cycles", 64'(cyc), 64'(40));
    @(negedge clk);
    rst_n    = 1'b1;
    ref_dout = '0;
    check_eq("abort_dout", 64'(bus.A_DOUT), 64'(0));
`ifdef SRAM_1P_BIST_FAIL_LOG_EN
    check_eq("abort_fail_addr", 64'(fail_addr), 64'(0));
`endif
    run_bist(1'b0, 1'b0, 0, cyc, dchg, dearly);
    check_eq("rerun_cycles", 64'(cyc), 64'(BIST_CYCLES));
    check_eq("rerun_done", 64'(done), 64'(1));
    check_eq("rerun_fail", 64'(fail), 64'(0));
`ifdef SRAM_1P_BIST_FAIL_LOG_EN
    check_eq("rerun_fail_xor", 64'(fail_xor), 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
